// File: rtl/ttpu_pkg.sv
// Shared TTPU types and dimensions used by the loader, timer and array stages.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ttpu_pkg;

    localparam int DIM    = 32;
    localparam int DATA_W = 16;

    typedef logic [DATA_W-1:0] elem_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        GAP
    } loader_state_t;

    // Number of anti-diagonals in an n x n matrix; the timer needs one enable
    // cycle per anti-diagonal.
    function automatic int run_len(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/matrix_loader_row_buffer.sv
// N x N operand store: one full row written per cycle, whole array readable.
// Latency: a row written at edge k is visible on rd_data after edge k.
// Backpressure: none; writes are accepted whenever wr_en is high.
//
// Ports:
//   clk, rst_n   clock and async active-low clear (array reset to zero)
//   wr_en        write the row selected by wr_row this edge
//   wr_row       destination row index
//   wr_data      row contents, element j = column j
//   rd_data      full array, rd_data[i][j] = row i, column j
module matrix_row_buffer
    import ttpu_pkg::*;
#(
    parameter int N     = DIM,
    parameter int W     = DATA_W,
    parameter int ROW_W = (N > 1) ? $clog2(N) : 1
)
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [ROW_W-1:0]               wr_row,
    input  logic [0:N-1][W-1:0]            wr_data,
    output logic [0:N-1][0:N-1][W-1:0]     rd_data
);

    logic [0:N-1][0:N-1][W-1:0] mem;

    // Rows not being written hold, so a partially reloaded matrix keeps the
    // tail of the previous one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (wr_en) begin
            mem[wr_row] <= wr_data;
        end
    end

    assign rd_data = mem;

endmodule

// File: rtl/matrix_loader.sv
// Collects an N x N matrix row by row, holds it on matrix_out, then enables the skew timer for 2N-1 cycles.
// Latency: timer_en rises the cycle after the Nth row handshake; done pulses the cycle after timer_en falls.
// Backpressure: in_ready is low during RUN/GAP and whenever flush is high; rows wait upstream.
//
// Ports:
//   clk, rst_n   clock and async active-low reset
//   flush        synchronous abort to IDLE (buffer contents kept)
//   in_valid     in_row carries a valid row
//   in_ready     loader can take a row this cycle
//   in_row       row data, element j = column j
//   matrix_out   buffered matrix to the timer
//   timer_en     registered timer enable, high for RUN_LEN cycles per matrix
//   busy         loader not in IDLE
//   done         one-cycle pulse when a sweep completes
module matrix_loader
    import ttpu_pkg::*;
#(
    parameter int N = DIM,
    parameter int W = DATA_W
)
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [0:N-1][W-1:0]            in_row,
    output logic [0:N-1][0:N-1][W-1:0]     matrix_out,
    output logic                           timer_en,
    output logic                           busy,
    output logic                           done
);

    localparam int RUN_LEN = run_len(N);
    localparam int ROW_W   = (N > 1) ? $clog2(N) : 1;
    localparam int RUN_W   = $clog2(2 * N);

    loader_state_t    state, state_nxt;
    logic [ROW_W-1:0] row_cnt, row_cnt_nxt;
    logic [RUN_W-1:0] run_cnt, run_cnt_nxt;
    logic             timer_en_nxt;
    logic             done_nxt;
    logic             row_hs;
    logic             last_row;
    logic             run_last;

    assign row_hs   = in_valid && in_ready;
    assign last_row = (row_cnt == ROW_W'(N - 1));
    assign run_last = (run_cnt == RUN_W'(RUN_LEN - 1));

    // State and counter register; timer_en/done are flopped from the next
    // state so they line up exactly with the RUN and GAP cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            row_cnt  <= '0;
            run_cnt  <= '0;
            timer_en <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            row_cnt  <= row_cnt_nxt;
            run_cnt  <= run_cnt_nxt;
            timer_en <= timer_en_nxt;
            done     <= done_nxt;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_nxt   = state;
        row_cnt_nxt = row_cnt;
        run_cnt_nxt = run_cnt;
        if (flush) begin
            state_nxt   = IDLE;
            row_cnt_nxt = '0;
            run_cnt_nxt = '0;
        end else begin
            case (state)
                // IDLE and LOAD share the row path: row_cnt is 0 in IDLE, so
                // last_row is already true there when N==1 and the loader goes
                // straight to RUN.
                IDLE, LOAD: begin
                    if (row_hs) begin
                        if (last_row) begin
                            state_nxt   = RUN;
                            row_cnt_nxt = '0;
                        end else begin
                            state_nxt   = LOAD;
                            row_cnt_nxt = row_cnt + ROW_W'(1);
                        end
                    end
                end
                RUN: begin
                    if (run_last) begin
                        state_nxt   = GAP;
                        run_cnt_nxt = '0;
                    end else begin
                        run_cnt_nxt = run_cnt + RUN_W'(1);
                    end
                end
                GAP: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt   = IDLE;
                    row_cnt_nxt = '0;
                    run_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Output decode.
    always_comb begin
        in_ready     = ((state == IDLE) || (state == LOAD)) && !flush;
        busy         = (state != IDLE);
        timer_en_nxt = (state_nxt == RUN);
        done_nxt     = (state_nxt == GAP);
    end

    matrix_row_buffer #(
        .N     (N),
        .W     (W),
        .ROW_W (ROW_W)
    ) u_row_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (row_hs),
        .wr_row  (row_cnt),
        .wr_data (in_row),
        .rd_data (matrix_out)
    );

endmodule

// File: tb/tb_matrix_loader.sv
// Randomized scoreboard bench for matrix_loader.
// Latency: n/a (testbench).
// Backpressure: the driver holds in_valid until in_ready is seen.
module tb_matrix_loader;
    import ttpu_pkg::*;

    localparam int N       = DIM;
    localparam int W       = DATA_W;
    localparam int RUN_LEN = 2 * N - 1;

    typedef logic [0:N-1][W-1:0]        row_t;
    typedef logic [0:N-1][0:N-1][W-1:0] mat_t;

    typedef struct {
        mat_t mat;
        int   start_cyc;
        int   done_cyc;
    } sweep_t;

    logic clk;
    logic rst_n;
    logic flush;
    logic in_valid;
    logic in_ready;
    row_t in_row;
    mat_t matrix_out;
    logic timer_en;
    logic busy;
    logic done;

    matrix_loader #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_row     (in_row),
        .matrix_out (matrix_out),
        .timer_en   (timer_en),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_count = 0;
    int last_done_cyc = -1;
    int first_hs = 0;
    int last_hs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    sweep_t sb_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_row(input string name, input row_t act, input row_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int j = 0; j < N; j++) begin
                if (act[j] !== exp[j]) begin
                    $display("FAIL %s: col %0d got %h, expected %h", name, j, act[j], exp[j]);
                    break;
                end
            end
        end
    endtask

    task automatic chk_mat(input string name, input mat_t act, input mat_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            begin : find
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        if (act[i][j] !== exp[i][j]) begin
                            $display("FAIL %s: [%0d][%0d] got %h, expected %h (cycle %0d)",
                                     name, i, j, act[i][j], exp[i][j], cyc);
                            disable find;
                        end
            end
        end
    endtask

    // ---------------- reference model + monitor ----------------
    // Model: the buffer contents, how many rows of the current matrix have
    // arrived, how many enable cycles remain, and whether a done is owed.
    mat_t   model_mat = '0;
    int     rows_in = 0;
    int     sweep_left = 0;
    bit     done_now = 0;
    bit     in_run = 0;
    bit     prev_ten = 0;
    bit     stable_ok = 1;
    int     run_seen = 0;
    sweep_t cur;

    always @(negedge clk) begin
        bit exp_ten, exp_rdy, exp_busy;
        if (!rst_n) begin
            model_mat  = '0;
            rows_in    = 0;
            sweep_left = 0;
            done_now   = 0;
            in_run     = 0;
            prev_ten   = 0;
            sb_q.delete();
        end else begin
            exp_ten  = (sweep_left > 0);
            exp_rdy  = !exp_ten && !done_now && !flush;
            exp_busy = (rows_in != 0) || exp_ten || done_now;
            chk("timer_en", int'(timer_en), int'(exp_ten));
            chk("done", int'(done), int'(done_now));
            chk("in_ready", int'(in_ready), int'(exp_rdy));
            chk("busy", int'(busy), int'(exp_busy));
            chk_mat("matrix_out", matrix_out, model_mat);

            // Scoreboard: each completed load must produce one sweep.
            if (timer_en && !prev_ten) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_sweep", 1, 0);
                end else begin
                    cur = sb_q.pop_front();
                    chk("sweep_start_cycle", cyc, cur.start_cyc);
                    chk_mat("sweep_matrix", matrix_out, cur.mat);
                    in_run    = 1;
                    run_seen  = 0;
                    stable_ok = 1;
                end
            end
            if (in_run && timer_en) begin
                run_seen++;
                if (matrix_out !== cur.mat) stable_ok = 0;
            end
            if (done) begin
                if (!in_run) begin
                    chk("done_without_sweep", 1, 0);
                end else begin
                    chk("run_length", run_seen, RUN_LEN);
                    chk("done_cycle", cyc, cur.done_cyc);
                    chk("matrix_stable_in_run", int'(stable_ok), 1);
                    in_run = 0;
                end
                done_count++;
                last_done_cyc = cyc;
            end
            prev_ten = timer_en;

            // Advance the model across the coming edge.
            if (flush) begin
                rows_in    = 0;
                sweep_left = 0;
                done_now   = 0;
                in_run     = 0;
            end else if (sweep_left > 0) begin
                sweep_left--;
                done_now = (sweep_left == 0);
            end else if (done_now) begin
                done_now = 0;
            end else if (in_valid) begin
                model_mat[rows_in] = in_row;
                rows_in++;
                if (rows_in == N) begin
                    rows_in    = 0;
                    sweep_left = RUN_LEN;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic mat_t rand_mat();
        mat_t m;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                m[i][j] = W'($urandom);
        return m;
    endfunction

    function automatic row_t rand_row();
        row_t r;
        for (int j = 0; j < N; j++) r[j] = W'($urandom);
        return r;
    endfunction

    // gap_mode: 0 continuous, 1 valid every third cycle, 2 random gaps.
    // Must be entered just after a rising edge; returns just after one.
    task automatic send_rows(input mat_t m, input int first, input int last, input int gap_mode);
        for (int i = first; i <= last; i++) begin
            int  waited = 0;
            int  ngap;
            bit  ok = 0;
            in_valid = 1'b1;
            in_row   = m[i];
            while (!ok && waited < 300) begin
                @(negedge clk);
                if (in_ready) ok = 1;
                else waited++;
            end
            if (!ok) chk("handshake_timeout", i, -1);
            if (i == first) first_hs = cyc;
            last_hs = cyc;
            if (ok && i == N - 1)
                sb_q.push_back('{mat: m, start_cyc: cyc + 1, done_cyc: cyc + RUN_LEN + 1});
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_row   = rand_row();
            ngap = (gap_mode == 1) ? 2 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
            if (i == last) ngap = 0;
            repeat (ngap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_done(input int budget);
        int dc = done_count;
        int k  = 0;
        while (done_count == dc && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (done_count == dc) chk("done_timeout", k, -1);
        #1;
    endtask

    mat_t pat, r1, bmat, cmat, dmat, emat, fmat;
    int   dc0;

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_row   = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                pat[i][j] = W'(i * 32 + j);

        // Reset values.
        #1;
        chk("rst_timer_en", int'(timer_en), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk_mat("rst_matrix", matrix_out, '0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full load with continuous valid.
        dc0 = done_count;
        send_rows(pat, 0, N - 1, 0);
        chk("cont_handshake_span", last_hs - first_hs, N - 1);
        repeat (10) @(negedge clk);
        chk("cont_run_timer_en", int'(timer_en), 1);
        chk("cont_elem_5_7", int'(matrix_out[5][7]), 167);
        wait_done(200);
        chk("cont_one_done", done_count - dc0, 1);

        // Random matrix with random gaps, then the pattern again with gaps.
        r1 = rand_mat();
        send_rows(r1, 0, N - 1, 2);
        wait_done(200);
        send_rows(pat, 0, N - 1, 1);
        chk("gapped_handshake_span", last_hs - first_hs, 3 * (N - 1));
        wait_done(200);
        chk_mat("gapped_final", matrix_out, pat);

        // Backpressure: next matrix's row 0 (all FFFF) held during RUN/GAP.
        r1 = rand_mat();
        send_rows(r1, 0, N - 1, 2);
        bmat = rand_mat();
        for (int j = 0; j < N; j++) bmat[0][j] = 16'hFFFF;
        send_rows(bmat, 0, 0, 0);
        chk("bp_accept_after_done", first_hs, last_done_cyc + 1);
        send_rows(bmat, 1, N - 1, 0);
        wait_done(200);

        // Flush in LOAD after 10 rows, with in_valid high in the same cycle.
        cmat = rand_mat();
        send_rows(cmat, 0, 9, 0);
        in_valid = 1'b1;
        in_row   = rand_row();
        flush    = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_busy", int'(busy), 0);
        chk("flush_in_ready_back", int'(in_ready), 1);
        @(posedge clk);
        #1;
        dmat = rand_mat();
        send_rows(dmat, 0, 0, 0);
        @(negedge clk);
        chk_row("flush_row0_new", matrix_out[0], dmat[0]);
        chk_row("flush_row9_kept", matrix_out[9], cmat[9]);
        chk_row("flush_row10_kept", matrix_out[10], bmat[10]);
        chk_row("flush_row31_kept", matrix_out[31], bmat[31]);
        @(posedge clk);
        #1;
        send_rows(dmat, 1, N - 1, 2);

        // Flush in RUN at run_cnt = 20.
        begin
            int k = 0;
            while (!timer_en && k < 10) begin
                @(negedge clk);
                k++;
            end
            chk("run_started", int'(timer_en), 1);
        end
        repeat (20) @(posedge clk);
        #1;
        dc0   = done_count;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("run_flush_timer_en", int'(timer_en), 0);
        chk("run_flush_busy", int'(busy), 0);
        repeat (80) @(posedge clk);
        #1;
        chk("run_flush_no_done", done_count, dc0);

        // Following full load sweeps normally.
        emat = rand_mat();
        send_rows(emat, 0, N - 1, 2);
        wait_done(200);
        chk("post_flush_done", done_count - dc0, 1);

        for (int t = 0; t < 2; t++) begin
            emat = rand_mat();
            send_rows(emat, 0, N - 1, 2);
            wait_done(200);
        end

        // Asynchronous reset in the middle of RUN.
        fmat = rand_mat();
        send_rows(fmat, 0, N - 1, 0);
        repeat (5) @(negedge clk);
        chk("pre_reset_timer_en", int'(timer_en), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_timer_en", int'(timer_en), 0);
        chk("async_rst_done", int'(done), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk_mat("async_rst_matrix", matrix_out, '0);
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute guard against a stuck run.
    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete, errors %0d", errors);
        $fatal(1);
    end

endmodule
